median_window_feeder: RTL
=========================

Name: median_window_feeder

Overview:
- Transmitter/driver for the 9-tap median core's streaming interface.
- Buffers an upstream 8-bit sample stream (valid/ready) in a FIFO.
- Bursts N-sample windows into the core when the core raises in_ready, with configurable stride for sliding or block windows.
- Captures each median on the core's one-cycle out_ready pulse and presents it downstream on a valid/ready register, with a response timeout.

Parameters:
- N, 9, window length sent per burst; must match the core.
- STRIDE, 9, samples retired from the FIFO per window; legal range 1..N.
- DEPTH, 16, FIFO entries; power of two, at least N.
- TIMEOUT, 15, max cycles to wait for the core's result pulse.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  upstream sample valid.
- s_data  in  8  upstream sample.
- s_ready  out  1  FIFO can accept; equals !rst && count<DEPTH.
- core_in_ready  in  1  core ready for a new window.
- core_in_valid  out  1  sample strobe to core; registered.
- core_in  out  8  sample to core; registered.
- core_out_ready  in  1  one-cycle median-valid pulse from core.
- core_out  in  8  median from core.
- m_valid  out  1  result valid downstream.
- m_data  out  8  median result.
- m_ready  in  1  downstream accept.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- timeout_err  out  1  sticky; set on response timeout.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; FIFO pointers and count go to 0.
  - core_in_valid=0, core_in=0, m_valid=0, m_data=0, timeout_err=0, s_ready=0.
  - Asserting rst mid-burst aborts the burst immediately, drops FIFO contents, and never completes a partial window.
- FIFO push: push occurs when s_valid && s_ready.
- FIFO occupancy update, same cycle: count_next = count + push - (retire ? STRIDE : 0). Simultaneous push and retire are both honoured.
- States: IDLE, WAIT_CORE, SEND, WAIT_RES, HOLD.
- IDLE -> WAIT_CORE when count>=N and m_valid==0.
- WAIT_CORE -> SEND on the first cycle core_in_ready==1.
  - The next cycle, core_in_valid=1 and core_in=FIFO[rd_ptr+0].
- SEND:
  - core_in_valid stays high for exactly N consecutive cycles.
  - Beat k (0..N-1) carries FIFO[rd_ptr+k], with addresses wrapping modulo DEPTH.
  - Samples are peeked, not popped, during the burst.
  - On the last beat, retire: rd_ptr += STRIDE and count -= STRIDE.
  - Next state WAIT_RES; core_in_valid=0 from the following cycle.
- Never assert core_in_valid outside SEND; the core shifts on every strobe.
- WAIT_RES:
  - A timer counts cycles in this state.
  - On core_out_ready=1: m_data<=core_out, m_valid<=1, go to HOLD.
  - If the timer reaches TIMEOUT without a pulse: timeout_err<=1, go to IDLE, no result produced.
  - A core_out_ready pulse in any other state is ignored.
- HOLD:
  - m_valid and m_data stay stable until m_ready.
  - On m_valid && m_ready: m_valid<=0, go to IDLE.
  - Upstream pushes continue during HOLD.
- Latency:
  - Window start (core_in_ready seen) to first strobe: 1 cycle.
  - The core then needs N strobes plus its compute time before its result pulse.
  - Result pulse to m_valid: 1 cycle.
- Sliding mode (STRIDE<N): consecutive windows overlap by N-STRIDE samples. The overlap samples stay in the FIFO and are re-sent.
- Full FIFO: s_ready=0; an upstream sample offered while full is not accepted.
- Empty or under-filled FIFO (count<N): stay in IDLE; no partial window is ever sent.
- fifo_count reflects the registered count; it never exceeds DEPTH and never underflows.
- timeout_err clears only on reset.

Test Plan:
- Block window: push 1..9 (STRIDE=9); core model returns median 5 → exactly 9 strobes carry 1,2,…,9 in order; m_valid rises with m_data=5; fifo_count returns to 0.
- Sliding: STRIDE=1, push 1..10 → first window 1..9, second window 2..10; fifo_count=9 after first retire; two results, 5 then 6.
- Backpressure: hold m_ready=0 for 20 cycles with 18 samples buffered → second window not started; m_data stable; core_in_valid stays 0 until m_ready accepts.
- FIFO full/simultaneous: fill to DEPTH=16 → s_ready=0; on the retire cycle with s_valid=1 → push accepted next cycle; count = 16-9+1 = 8.
- Timeout: core never pulses out_ready → after 15 WAIT_RES cycles timeout_err=1; FSM back in IDLE; m_valid stays 0.
- Reset mid-burst: assert rst at beat 4 → core_in_valid drops asynchronously, fifo_count=0, s_ready=0 during reset; after release a fresh 9-sample window sends correctly.

Source files
------------

// File: rtl/median_window_feeder.sv
// median_window_feeder
//   Buffers an upstream 8-bit sample stream in a FIFO and bursts N-sample
//   windows into a 9-tap median core. After each burst it waits for the
//   core's one-cycle result pulse and holds the median on a valid/ready
//   output register. If the pulse never arrives, a sticky error flag is set.
//
// Ports
//   clk, rst          clock (rising edge), async active-high reset
//   s_valid/s_data    upstream sample stream; s_ready = room in FIFO
//   core_in_ready     core can take a new window
//   core_in_valid     registered sample strobe to core (high only while sending)
//   core_in           registered sample to core
//   core_out_ready    one-cycle median-valid pulse from core
//   core_out          median from core
//   m_valid/m_data    captured median, held until m_ready
//   fifo_count        registered FIFO occupancy
//   timeout_err       sticky; set when the core fails to answer in time
module median_window_feeder #(
    parameter int N       = 9,
    parameter int STRIDE  = 9,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    input  logic [7:0]             s_data,
    output logic                   s_ready,
    input  logic                   core_in_ready,
    output logic                   core_in_valid,
    output logic [7:0]             core_in,
    input  logic                   core_out_ready,
    input  logic [7:0]             core_out,
    output logic                   m_valid,
    output logic [7:0]             m_data,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(N + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] N_C       = CW'(N);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] STRIDE_C  = CW'(STRIDE);
    localparam logic [AW-1:0] STRIDE_A  = AW'(STRIDE);
    localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CORE,
        S_SEND,
        S_WAIT_RES,
        S_HOLD
    } state_t;

    state_t          r_state, w_nxt;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_cnt;
    logic [BW-1:0]   r_beat;      // index of the beat currently on core_in
    logic [TW-1:0]   r_tmr;
    logic            r_civ;
    logic [7:0]      r_ci;
    logic            r_m_valid;
    logic [7:0]      r_m_data;
    logic            r_terr;

    logic            w_push, w_start, w_retire, w_capture, w_tmo;
    logic [BW-1:0]   w_peek;
    logic [AW-1:0]   w_rd_addr;
    logic [CW-1:0]   w_cnt_nxt;

    assign s_ready       = !rst && (r_cnt < DEPTH_C);
    assign w_push        = s_valid && s_ready;
    assign w_cnt_nxt     = r_cnt + CW'(w_push) - (w_retire ? STRIDE_C : '0);

    // Beat to load into the output register at the next edge. Samples are
    // only peeked; the read pointer moves once, at the end of the burst.
    assign w_peek        = w_start ? '0 : r_beat + BW'(1);
    assign w_rd_addr     = r_rd_ptr + AW'(w_peek);

    assign core_in_valid = r_civ;
    assign core_in       = r_ci;
    assign m_valid       = r_m_valid;
    assign m_data        = r_m_data;
    assign fifo_count    = r_cnt;
    assign timeout_err   = r_terr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt     = r_state;
        w_start   = 1'b0;
        w_retire  = 1'b0;
        w_capture = 1'b0;
        w_tmo     = 1'b0;
        case (r_state)
            S_IDLE:
                if (r_cnt >= N_C && !r_m_valid) w_nxt = S_WAIT_CORE;
            S_WAIT_CORE:
                if (core_in_ready) begin
                    w_start = 1'b1;
                    w_nxt   = S_SEND;
                end
            S_SEND:
                if (r_beat == LAST_BEAT) begin
                    w_retire = 1'b1;
                    w_nxt    = S_WAIT_RES;
                end
            S_WAIT_RES:
                // A pulse on the final allowed cycle still wins over timeout.
                if (core_out_ready) begin
                    w_capture = 1'b1;
                    w_nxt     = S_HOLD;
                end else if (r_tmr == TMO_LAST) begin
                    w_tmo = 1'b1;
                    w_nxt = S_IDLE;
                end
            S_HOLD:
                if (r_m_valid && m_ready) w_nxt = S_IDLE;
            default:
                w_nxt = S_IDLE;
        endcase
    end

    // Storage has no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_beat    <= '0;
            r_tmr     <= '0;
            r_civ     <= 1'b0;
            r_ci      <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_terr    <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_push)   r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_retire) r_rd_ptr <= r_rd_ptr + STRIDE_A;

            if (w_start) begin
                r_civ  <= 1'b1;
                r_ci   <= r_mem[w_rd_addr];
                r_beat <= '0;
            end else if (r_state == S_SEND) begin
                if (w_retire) begin
                    r_civ <= 1'b0;
                end else begin
                    r_ci   <= r_mem[w_rd_addr];
                    r_beat <= w_peek;
                end
            end

            if (w_retire)                  r_tmr <= '0;
            else if (r_state == S_WAIT_RES) r_tmr <= r_tmr + TW'(1);

            if (w_capture) begin
                r_m_valid <= 1'b1;
                r_m_data  <= core_out;
            end else if (r_state == S_HOLD && m_ready) begin
                r_m_valid <= 1'b0;
            end

            if (w_tmo) r_terr <= 1'b1;
        end
    end

endmodule
